// File: rtl/dvp_capture_ctrl_if.sv
// DVP camera pins in, qualified byte stream out.
// The capture controller takes the slave side.
interface dvp_capture_ctrl_if #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 16,
    parameter int BPP    = 3
);
    localparam int PW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          byte_valid;
    logic [7:0]    data_q;
    logic [PW-1:0] pix_phase;
    logic          pix_last;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    modport master (
        output vsync, href, data,
        input  byte_valid, data_q, pix_phase,
        input  pix_last, pix_x, pix_y
    );

    modport slave (
        input  vsync, href, data,
        output byte_valid, data_q, pix_phase,
        output pix_last, pix_x, pix_y
    );
endinterface

// File: rtl/dvp_capture_ctrl.sv
// DVP frame-capture sequencer: arms on start, locks to the next
// full frame, qualifies bytes and checks line/frame geometry.
module dvp_capture_ctrl #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 16,
    parameter int BPP    = 3
) (
    input  logic               clk,
    input  logic               rst,
    dvp_capture_ctrl_if.slave  dvp,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    output logic               frame_start,
    output logic               frame_done,
    output logic               line_err,
    output logic               frame_err,
    output logic               busy
);
    localparam int PW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LB = WIDTH * BPP;
    localparam int BW = $clog2(LB + 1);
    localparam int LW = $clog2(HEIGHT + 1);

    localparam logic [BW-1:0] LB_C   = BW'(LB);
    localparam logic [LW-1:0] H_C    = LW'(HEIGHT);
    localparam logic [LW-1:0] HL_C   = LW'(HEIGHT - 1);
    localparam logic [PW-1:0] PLAST  = PW'(BPP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        VBLANK,
        ACTIVE
    } state_t;

    state_t        state;
    logic          vs_q;
    logic          hr_q;
    logic          cont_q;
    logic          stop_pend;
    logic [BW-1:0] byte_cnt;
    logic [PW-1:0] ph_cnt;
    logic [XW-1:0] x_cnt;
    logic [LW-1:0] line_cnt;

    logic vs_rise;
    logic vs_fall;
    logic hr_fall;
    logic in_frame;
    logic sample;
    logic take;
    logic line_end;
    logic halt;

    assign vs_rise  = dvp.vsync & ~vs_q;
    assign vs_fall  = ~dvp.vsync & vs_q;
    assign hr_fall  = ~dvp.href & hr_q;
    assign in_frame = line_cnt < H_C;
    assign halt     = stop | stop_pend;

    // The frame-ending vsync edge wins over a byte in the same cycle.
    assign sample   = (state == ACTIVE) && dvp.href
                      && in_frame && !vs_rise;
    assign take     = sample && (byte_cnt < LB_C);
    assign line_end = (state == ACTIVE) && hr_fall && in_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vs_q           <= 1'b0;
            hr_q           <= 1'b0;
            cont_q         <= 1'b0;
            stop_pend      <= 1'b0;
            byte_cnt       <= '0;
            ph_cnt         <= '0;
            x_cnt          <= '0;
            line_cnt       <= '0;
            dvp.byte_valid <= 1'b0;
            dvp.data_q     <= '0;
            dvp.pix_phase  <= '0;
            dvp.pix_last   <= 1'b0;
            dvp.pix_x      <= '0;
            dvp.pix_y      <= '0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            vs_q           <= dvp.vsync;
            hr_q           <= dvp.href;
            dvp.data_q     <= dvp.data;
            dvp.byte_valid <= take;
            dvp.pix_last   <= take && (ph_cnt == PLAST);
            frame_start    <= take && (line_cnt == '0)
                              && (byte_cnt == '0);
            frame_done     <= 1'b0;

            if (take) begin
                dvp.pix_phase <= ph_cnt;
                dvp.pix_x     <= x_cnt;
                dvp.pix_y     <= line_cnt[YW-1:0];
                byte_cnt      <= byte_cnt + BW'(1);
                if (ph_cnt == PLAST) begin
                    ph_cnt <= '0;
                    x_cnt  <= x_cnt + XW'(1);
                end else begin
                    ph_cnt <= ph_cnt + PW'(1);
                end
            end

            if (state != IDLE && stop) begin
                stop_pend <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SYNC;
                        busy      <= 1'b1;
                        cont_q    <= continuous & ~stop;
                        stop_pend <= 1'b0;
                        line_err  <= 1'b0;
                        frame_err <= 1'b0;
                    end
                end
                SYNC: begin
                    if (halt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_rise) begin
                        state <= VBLANK;
                    end
                end
                VBLANK: begin
                    if (halt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_fall) begin
                        state    <= ACTIVE;
                        line_cnt <= '0;
                        byte_cnt <= '0;
                        ph_cnt   <= '0;
                        x_cnt    <= '0;
                    end
                end
                ACTIVE: begin
                    if (line_end) begin
                        if (byte_cnt != LB_C) begin
                            line_err <= 1'b1;
                        end
                        byte_cnt <= '0;
                        ph_cnt   <= '0;
                        x_cnt    <= '0;
                        line_cnt <= line_cnt + LW'(1);
                        if (line_cnt == HL_C) begin
                            frame_done <= 1'b1;
                            if (cont_q && !halt) begin
                                state <= VBLANK;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else if (vs_rise && in_frame) begin
                        frame_err <= 1'b1;
                        if (cont_q && !halt) begin
                            state <= VBLANK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl: table of single-shot frames
// plus hand-written arm, continuous/stop and reset sequences.
module tb_dvp_capture_ctrl;
    localparam int W = 10;
    localparam int H = 16;
    localparam int B = 3;

    logic clk;
    logic rst;
    logic start;
    logic continuous;
    logic stop;
    logic frame_start;
    logic frame_done;
    logic line_err;
    logic frame_err;
    logic busy;

    dvp_capture_ctrl_if #(.WIDTH(W), .HEIGHT(H), .BPP(B)) dvp ();

    dvp_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .BPP(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .dvp         (dvp),
        .start       (start),
        .continuous  (continuous),
        .stop        (stop),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int cnt_bv = 0;
    int cnt_pl = 0;
    int cnt_fs = 0;
    int cnt_fd = 0;
    int mon_err = 0;
    int last_y = -1;
    int cur_y = 0;
    int bil = 0;
    logic prev_bv = 1'b0;

    // Independent stream model: bytes 1,2,3 per pixel, lines split by gaps.
    always @(negedge clk) begin
        int ph;
        if (frame_start) cur_y = 0;
        if (dvp.byte_valid) begin
            if (!prev_bv) bil = 0;
            ph = bil % B;
            if (int'(dvp.pix_phase) != ph) mon_err++;
            if (int'(dvp.pix_x) != bil / B) mon_err++;
            if (int'(dvp.pix_y) != cur_y) mon_err++;
            if (int'(dvp.data_q) != ph + 1) mon_err++;
            if (dvp.pix_last != (ph == B - 1)) mon_err++;
            last_y = int'(dvp.pix_y);
            bil++;
            cnt_bv++;
            if (dvp.pix_last) cnt_pl++;
        end else begin
            if (prev_bv) cur_y++;
            if (dvp.pix_last) mon_err++;
        end
        if (frame_start) cnt_fs++;
        if (frame_done) cnt_fd++;
        prev_bv = dvp.byte_valid;
    end

    typedef struct {
        int nlines;
        int sline;
        int slen;
        int bv;
        int pl;
        int fd;
        int le;
        int fe;
        int ly;
    } vec_t;

    vec_t tbl[5];

    int b_bv, b_pl, b_fs, b_fd, b_me;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs_word();
        return int'({dvp.byte_valid, dvp.data_q, dvp.pix_phase,
                     dvp.pix_last, dvp.pix_x, dvp.pix_y,
                     frame_start, frame_done, line_err,
                     frame_err, busy});
    endfunction

    task automatic snap();
        b_bv = cnt_bv;
        b_pl = cnt_pl;
        b_fs = cnt_fs;
        b_fd = cnt_fd;
        b_me = mon_err;
    endtask

    // kind: 1 start, 2 stop, 3 reset, pulsed at byte 10 of the line
    task automatic send_line(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            dvp.href = 1'b1;
            dvp.data = 8'(i % B + 1);
            start = (kind == 1 && i == 10);
            stop  = (kind == 2 && i == 10);
            rst   = (kind == 3 && i == 10);
            tick();
            if (kind == 3 && i == 10)
                chk("rst_midframe_outs", outs_word(), 0);
        end
        dvp.href = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int nl, input int sl, input int slen,
                              input int kl, input int kind);
        dvp.vsync = 1'b1;
        repeat (4) tick();
        dvp.vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nl; l++)
            send_line((l == sl) ? slen : W * B, (l == kl) ? kind : 0);
        repeat (3) tick();
    endtask

    task automatic vs_pulse();
        dvp.vsync = 1'b1;
        repeat (3) tick();
        dvp.vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_start(input logic cont);
        start = 1'b1;
        continuous = cont;
        tick();
        start = 1'b0;
        continuous = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16, -1, 30, 480, 160, 1, 0, 0, 15};
        tbl[1] = '{16,  3, 27, 477, 159, 1, 1, 0, 15};
        tbl[2] = '{ 8, -1, 30, 240,  80, 0, 0, 1,  7};
        tbl[3] = '{16,  0, 12, 462, 154, 1, 1, 0, 15};
        tbl[4] = '{16, 15, 29, 479, 159, 1, 1, 0, 15};

        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        stop = 1'b0;
        dvp.vsync = 1'b0;
        dvp.href = 1'b0;
        dvp.data = 8'h00;
        repeat (3) tick();
        chk("reset_outs", outs_word(), 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) begin
            snap();
            pulse_start(1'b0);
            send_frame(tbl[k].nlines, tbl[k].sline, tbl[k].slen, -1, 0);
            if (tbl[k].nlines < H) vs_pulse();
            repeat (5) tick();
            chk($sformatf("v%0d_byte_valid", k), cnt_bv - b_bv, tbl[k].bv);
            chk($sformatf("v%0d_pix_last", k), cnt_pl - b_pl, tbl[k].pl);
            chk($sformatf("v%0d_frame_start", k), cnt_fs - b_fs, 1);
            chk($sformatf("v%0d_frame_done", k), cnt_fd - b_fd, tbl[k].fd);
            chk($sformatf("v%0d_line_err", k), int'(line_err), tbl[k].le);
            chk($sformatf("v%0d_frame_err", k), int'(frame_err), tbl[k].fe);
            chk($sformatf("v%0d_busy", k), int'(busy), 0);
            chk($sformatf("v%0d_stream", k), mon_err - b_me, 0);
            chk($sformatf("v%0d_last_y", k), last_y, tbl[k].ly);
        end

        // Arm during line 5 of a frame already in flight.
        snap();
        send_frame(H, -1, 30, 5, 1);
        chk("arm_mid_partial_bv", cnt_bv - b_bv, 0);
        chk("arm_mid_busy", int'(busy), 1);
        send_frame(H, -1, 30, -1, 0);
        repeat (5) tick();
        chk("arm_mid_bv", cnt_bv - b_bv, 480);
        chk("arm_mid_fs", cnt_fs - b_fs, 1);
        chk("arm_mid_fd", cnt_fd - b_fd, 1);
        chk("arm_mid_err", int'({line_err, frame_err}), 0);
        chk("arm_mid_busy_end", int'(busy), 0);
        chk("arm_mid_stream", mon_err - b_me, 0);

        // Continuous, stop during frame 2; frame 3 must be ignored.
        snap();
        pulse_start(1'b1);
        chk("cont_busy_rise", int'(busy), 1);
        send_frame(H, -1, 30, -1, 0);
        chk("cont_f1_fd", cnt_fd - b_fd, 1);
        chk("cont_f1_busy", int'(busy), 1);
        send_frame(H, -1, 30, 5, 2);
        send_frame(H, -1, 30, -1, 0);
        repeat (5) tick();
        chk("cont_fd", cnt_fd - b_fd, 2);
        chk("cont_fs", cnt_fs - b_fs, 2);
        chk("cont_bv", cnt_bv - b_bv, 960);
        chk("cont_busy_end", int'(busy), 0);
        chk("cont_err", int'({line_err, frame_err}), 0);

        // Reset at line 7, then a clean frame.
        snap();
        pulse_start(1'b0);
        send_frame(H, -1, 30, 7, 3);
        chk("rst_fd", cnt_fd - b_fd, 0);
        chk("rst_busy", int'(busy), 0);
        snap();
        pulse_start(1'b0);
        send_frame(H, -1, 30, -1, 0);
        repeat (5) tick();
        chk("post_rst_bv", cnt_bv - b_bv, 480);
        chk("post_rst_pl", cnt_pl - b_pl, 160);
        chk("post_rst_fd", cnt_fd - b_fd, 1);
        chk("post_rst_err", int'({line_err, frame_err}), 0);
        chk("post_rst_stream", mon_err - b_me, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
